fp_div_issue_ctrl: RTL and testbench

Control and exception front-end wrapped around the three-stage single-precision divider pipeline. It accepts operand pairs on a valid/ready handshake and classifies them. Special cases (zero, infinity, NaN, denormal, exponent overflow/underflow) are resolved locally without using the divider. Normal operations are issued to the divider; its mantissa is recombined with a locally computed sign and exponent and presented downstream with IEEE exception flags.

---
 rtl/fp_div_pkg.sv | 27 ++
 rtl/fp_operand_classify.sv | 38 +++
 rtl/fp_div_issue_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_fp_div_issue_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// ---------------------------------------------------------------------------
// fp_div_pkg
// Shared definitions for the divider issue/exception front-end:
//   - IEEE-754 single-precision constants (bias, quiet NaN, all-ones exponent)
//   - control FSM state encoding
//   - bit positions inside the 4-bit exception flag vector
// ---------------------------------------------------------------------------
package fp_div_pkg;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          EXP_MAX = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    // Flag vector layout: {invalid, div_by_zero, overflow, underflow}
    localparam int INV = 3;
    localparam int DZ  = 2;
    localparam int OF  = 1;
    localparam int UF  = 0;

endpackage : fp_div_pkg

// File: rtl/fp_operand_classify.sv
// ---------------------------------------------------------------------------
// fp_operand_classify
// Purely combinational classification of one IEEE-754 operand.
// Ports:
//   word       in   D_WIDTH  operand
//   is_zero    out  1        exponent field zero (denormals flushed to zero)
//   is_inf     out  1        exponent all ones, mantissa zero
//   is_nan     out  1        exponent all ones, mantissa non-zero
//   is_normal  out  1        any other encoding
// ---------------------------------------------------------------------------
module fp_operand_classify #(
    parameter int D_WIDTH = 32,
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23
) (
    input  logic [D_WIDTH-1:0] word,
    output logic               is_zero,
    output logic               is_inf,
    output logic               is_nan,
    output logic               is_normal
);

    logic [E_WIDTH-1:0] exp_field;
    logic [M_WIDTH-1:0] mant_field;
    logic               exp_all_ones;
    logic               mant_zero;

    assign exp_field    = word[M_WIDTH +: E_WIDTH];
    assign mant_field   = word[M_WIDTH-1:0];
    assign exp_all_ones = &exp_field;
    assign mant_zero    = (mant_field == '0);

    assign is_zero   = (exp_field == '0);
    assign is_inf    = exp_all_ones & mant_zero;
    assign is_nan    = exp_all_ones & ~mant_zero;
    assign is_normal = ~is_zero & ~exp_all_ones;

endmodule : fp_operand_classify

// File: rtl/fp_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fp_div_issue_ctrl
// Control and exception front-end around a fixed-latency mantissa divider.
// Special operands and exponent overflow/underflow are resolved locally; only
// normal/normal pairs with an in-range exponent are issued to the divider.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready only in IDLE)
//   in_a, in_b              dividend, divisor
//   div_a, div_b            captured operands to the divider
//   div_enable              one-cycle start pulse to the divider
//   div_result              divider output, mantissa bits only are used
//   out_valid/out_ready     result handshake
//   out_result, out_flags   quotient and {invalid, dz, overflow, underflow}
// ---------------------------------------------------------------------------
module fp_div_issue_ctrl
    import fp_div_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int DIV_LAT = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_a,
    input  logic [D_WIDTH-1:0] in_b,
    output logic [D_WIDTH-1:0] div_a,
    output logic [D_WIDTH-1:0] div_b,
    output logic               div_enable,
    input  logic [D_WIDTH-1:0] div_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_result,
    output logic [3:0]         out_flags
);

    // Exponent arithmetic needs two guard bits: sign plus one overflow bit.
    localparam int XW  = E_WIDTH + 2;
    localparam int WCW = $clog2(DIV_LAT + 1);

    state_t               state_reg;
    logic                 in_ready_reg;
    logic                 div_enable_reg;
    logic                 out_valid_reg;
    logic [D_WIDTH-1:0]   div_a_reg;
    logic [D_WIDTH-1:0]   div_b_reg;
    logic [D_WIDTH-1:0]   out_result_reg;
    logic [3:0]           out_flags_reg;
    logic [WCW-1:0]       wait_cnt_reg;
    logic [WCW-1:0]       wait_cnt_next;
    logic                 sign_reg;
    logic [E_WIDTH-1:0]   exp_reg;

    logic a_zero, a_inf, a_nan, a_normal;
    logic b_zero, b_inf, b_nan, b_normal;

    fp_operand_classify #(.D_WIDTH(D_WIDTH), .E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH)) u_class_a (
        .word      (in_a),
        .is_zero   (a_zero),
        .is_inf    (a_inf),
        .is_nan    (a_nan),
        .is_normal (a_normal)
    );

    fp_operand_classify #(.D_WIDTH(D_WIDTH), .E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH)) u_class_b (
        .word      (in_b),
        .is_zero   (b_zero),
        .is_inf    (b_inf),
        .is_nan    (b_nan),
        .is_normal (b_normal)
    );

    // Sign and exponent are always computed here, never taken from the divider.
    logic                  sign_next;
    logic                  mant_a_lt_b;
    logic signed [XW-1:0]  exp_calc;
    logic [D_WIDTH-1:0]    inf_word;
    logic [D_WIDTH-1:0]    zero_word;

    assign sign_next   = in_a[D_WIDTH-1] ^ in_b[D_WIDTH-1];
    assign mant_a_lt_b = ({1'b1, in_a[M_WIDTH-1:0]} < {1'b1, in_b[M_WIDTH-1:0]});
    // A smaller dividend mantissa yields a quotient in [0.5,1): renormalising
    // by one place costs one from the exponent.
    assign exp_calc    = XW'({2'b00, in_a[M_WIDTH +: E_WIDTH]})
                       - XW'({2'b00, in_b[M_WIDTH +: E_WIDTH]})
                       + XW'(BIAS)
                       - XW'(mant_a_lt_b);
    assign inf_word    = {sign_next, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    assign zero_word   = {sign_next, {(D_WIDTH-1){1'b0}}};

    // Special-case resolution in priority order. Anything that survives to
    // the final branch is a normal/normal pair that must go to the divider.
    logic               special_next;
    logic [D_WIDTH-1:0] special_result;
    logic [3:0]         special_flags;

    always_comb begin
        special_next   = 1'b1;
        special_result = '0;
        special_flags  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_result     = D_WIDTH'(QNAN);
            special_flags[INV] = 1'b1;
        end else if (a_normal && b_zero) begin
            special_result     = inf_word;
            special_flags[DZ]  = 1'b1;
        end else if (a_inf) begin
            special_result     = inf_word;
        end else if (a_zero || b_inf) begin
            special_result     = zero_word;
        end else if (exp_calc >= $signed(XW'(EXP_MAX))) begin
            special_result     = inf_word;
            special_flags[OF]  = 1'b1;
        end else if (exp_calc <= $signed(XW'(0))) begin
            special_result     = zero_word;
            special_flags[UF]  = 1'b1;
        end else begin
            special_next       = 1'b0;
        end
    end

    assign wait_cnt_next = wait_cnt_reg - 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            div_enable_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            div_a_reg      <= '0;
            div_b_reg      <= '0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
            wait_cnt_reg   <= '0;
            sign_reg       <= 1'b0;
            exp_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_ready_reg && in_valid) begin
                        div_a_reg    <= in_a;
                        div_b_reg    <= in_b;
                        sign_reg     <= sign_next;
                        exp_reg      <= exp_calc[E_WIDTH-1:0];
                        in_ready_reg <= 1'b0;
                        if (special_next) begin
                            out_result_reg <= special_result;
                            out_flags_reg  <= special_flags;
                            out_valid_reg  <= 1'b1;
                            state_reg      <= HOLD;
                        end else begin
                            div_enable_reg <= 1'b1;
                            state_reg      <= ISSUE;
                        end
                    end else begin
                        // Ready rises one cycle after reset release.
                        in_ready_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    div_enable_reg <= 1'b0;
                    wait_cnt_reg   <= WCW'(DIV_LAT);
                    state_reg      <= WAIT;
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_next;
                    if (wait_cnt_next == '0) begin
                        out_result_reg <= {sign_reg, exp_reg, div_result[M_WIDTH-1:0]};
                        out_flags_reg  <= '0;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Divider exponent/sign bits are recomputed locally and never consumed.
    logic unused_div_bits;
    assign unused_div_bits = ^div_result[D_WIDTH-1:M_WIDTH];

    assign in_ready   = in_ready_reg;
    assign div_enable = div_enable_reg;
    assign div_a      = div_a_reg;
    assign div_b      = div_b_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_flags  = out_flags_reg;

endmodule : fp_div_issue_ctrl

// File: tb/tb_fp_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_div_issue_ctrl
// Bench for the divider issue front-end. A small divider stand-in returns the
// true truncated mantissa quotient exactly DIV_LAT cycles after div_enable and
// noise otherwise. A per-cycle checker predicts handshake timing, divider
// issue and the result word from IEEE rules on every cycle out of reset.
// ---------------------------------------------------------------------------
module tb_fp_div_issue_ctrl;

    localparam int DIV_LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_enable;
    logic [31:0] div_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    fp_div_issue_ctrl #(.D_WIDTH(32), .E_WIDTH(8), .M_WIDTH(23), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_enable (div_enable),
        .div_result (div_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Truncated 23-bit quotient mantissa of two normal operands.
    function automatic logic [22:0] div_mant(input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        longint q;
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        if (ma < mb) q = (ma <<< 24) / mb;
        else         q = (ma <<< 23) / mb;
        return q[22:0];
    endfunction

    // IEEE-level reference: result word, flags, and whether the divider is used.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic [3:0] fl,
                                      output bit via_div);
        int ea;
        int eb;
        int e;
        bit s;
        bit za, zb, ia, ib, na, nb;
        logic [31:0] inf_w;
        logic [31:0] zero_w;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        inf_w  = {s, 8'hFF, 23'd0};
        zero_w = {s, 31'd0};
        via_div = 1'b0;
        fl = 4'b0000;
        res = 32'd0;
        if (na || nb || (za && zb) || (ia && ib)) begin
            res = 32'h7FC0_0000;
            fl  = 4'b1000;
        end else if (ia) begin
            res = inf_w;
        end else if (zb) begin
            res = inf_w;
            fl  = 4'b0100;
        end else if (za || ib) begin
            res = zero_w;
        end else begin
            e = ea - eb + 127 - ((a[22:0] < b[22:0]) ? 1 : 0);
            if (e >= 255) begin
                res = inf_w;
                fl  = 4'b0010;
            end else if (e <= 0) begin
                res = zero_w;
                fl  = 4'b0001;
            end else begin
                via_div = 1'b1;
                res = {s, 8'(e), div_mant(a, b)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        int          k;
        logic [7:0]  e;
        logic [22:0] m;
        k = int'($urandom_range(0, 9));
        m = 23'($urandom);
        if ($urandom_range(0, 3) == 0) m = 23'd0;
        case (k)
            0:       e = 8'd0;
            1:       begin e = 8'hFF; m = 23'd0; end
            2:       begin e = 8'hFF; m = m | 23'd1; end
            3:       e = 8'($urandom_range(1, 20));
            4:       e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Divider stand-in: valid quotient only in the DIV_LAT-th cycle after the pulse.
    int          stub_cd = 0;
    logic [22:0] stub_q = '0;

    always @(negedge clk) begin
        if (div_enable) begin
            stub_cd = DIV_LAT;
            stub_q  = div_mant(div_a, div_b);
        end
    end

    always @(posedge clk) begin
        #1;
        if (stub_cd > 0) begin
            stub_cd--;
            if (stub_cd == 0) div_result = {9'($urandom), stub_q};
            else              div_result = $urandom;
        end else begin
            div_result = $urandom;
        end
    end

    // Per-cycle checker against the reference model.
    bit          mdl_busy = 1'b0;
    bit          mdl_skip_ready = 1'b1;
    bit          mdl_div;
    int          mdl_acc;
    int          mdl_due;
    int          age;
    logic [31:0] mdl_a;
    logic [31:0] mdl_b;
    logic [31:0] mdl_res;
    logic [3:0]  mdl_fl;

    always @(negedge clk) begin
        if (!reset_n) begin
            mdl_busy       = 1'b0;
            mdl_skip_ready = 1'b1;
        end else if (!mdl_busy) begin
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_div_enable", 32'(div_enable), 32'd0);
            check("idle_in_ready", 32'(in_ready), mdl_skip_ready ? 32'd0 : 32'd1);
            if (!mdl_skip_ready && in_valid) begin
                mdl_busy = 1'b1;
                mdl_acc  = cyc;
                mdl_a    = in_a;
                mdl_b    = in_b;
                ref_model(in_a, in_b, mdl_res, mdl_fl, mdl_div);
                mdl_due  = mdl_div ? DIV_LAT + 2 : 1;
                $display("accept a=%h b=%h expect %h flags %b via_div=%0d cycle %0d",
                         in_a, in_b, mdl_res, mdl_fl, mdl_div, cyc);
            end
            mdl_skip_ready = 1'b0;
        end else begin
            age = cyc - mdl_acc;
            check("busy_in_ready", 32'(in_ready), 32'd0);
            check("div_enable", 32'(div_enable), 32'(mdl_div && age == 1));
            if (mdl_div && age >= 1 && age <= DIV_LAT + 1) begin
                check("div_a", div_a, mdl_a);
                check("div_b", div_b, mdl_b);
            end
            if (age < mdl_due) begin
                check("early_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_valid", 32'(out_valid), 32'd1);
                check("out_result", out_result, mdl_res);
                check("out_flags", 32'(out_flags), 32'(mdl_fl));
                if (out_ready) mdl_busy = 1'b0;
            end
        end
    end

    task automatic pin(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] fl, input bit d);
        logic [31:0] r;
        logic [3:0]  f;
        bit          v;
        ref_model(a, b, r, f, v);
        check("pin_result", r, res);
        check("pin_flags", 32'(f), 32'(fl));
        check("pin_via_div", 32'(v), 32'(d));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("accept_in_time", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("return_idle_in_time", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   32'(in_ready), 32'd0);
        check({tag, "_out_valid"},  32'(out_valid), 32'd0);
        check({tag, "_out_result"}, out_result, 32'd0);
        check({tag, "_out_flags"},  32'(out_flags), 32'd0);
        check({tag, "_div_enable"}, 32'(div_enable), 32'd0);
        check({tag, "_div_a"},      div_a, 32'd0);
        check({tag, "_div_b"},      div_b, 32'd0);
    endtask

    logic [31:0] dir_a [8] = '{32'h40C0_0000, 32'h3F80_0000, 32'h0000_0000, 32'hFF80_0000,
                               32'h7F00_0000, 32'h0080_0000, 32'h3F80_0000, 32'h7FC1_2345};
    logic [31:0] dir_b [8] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000,
                               32'h0080_0000, 32'h7F00_0000, 32'h4040_0000, 32'h3F80_0000};

    initial begin
        // Reference model pinned by hand-worked values.
        pin(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 1'b1);
        pin(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1'b0);
        pin(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1'b0);
        pin(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1'b0);
        pin(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0010, 1'b0);
        pin(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0001, 1'b0);
        pin(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 1'b1);

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed operations with a always-ready sink.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(dir_a[i], dir_b[i]);
            wait_idle();
        end

        // Back-pressure: sink stalled while a second operand pair waits.
        out_ready = 1'b0;
        send(32'h40C0_0000, 32'h4000_0000);
        in_a = 32'h4110_0000;
        in_b = 32'h4040_0000;
        in_valid = 1'b1;
        repeat (DIV_LAT + 8) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h4110_0000, 32'h4040_0000);
        wait_idle();

        // Reset while waiting on the divider; its late answer must be dropped.
        send(32'h40C0_0000, 32'h4000_0000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midwait_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(32'h40C0_0000, 32'h4000_0000);
        wait_idle();

        // Randomised traffic with random sink stalls.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = rand_operand();
            in_b      = rand_operand();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fp_div_issue_ctrl
